bcd_to_bin_seq: RTL and testbench

//  Sequential packed-BCD to binary converter, the inverse of the score/number

---
 rtl/bcd_to_bin_seq.sv | 137 +++++++++++++
 tb/tb_bcd_to_bin_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to unsigned binary converter: one multiply-by-ten-and-add
// step per clock, most-significant digit first, with a start/busy/done handshake.
module bcd_to_bin_seq #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);

  // One spare bit beyond 4*DIGITS keeps even all-0xF digit strings from wrapping.
  localparam int ACC_W = 4 * DIGITS + 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                bad_q, bad_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [BIN_W-1:0]    bin_q, bin_d;

  logic [3:0]            digit_s;
  logic [ACC_W-1:0]      step_acc_s;
  logic                  step_bad_s;
  logic [ACC_W+BIN_W-1:0] acc_ext_s;
  logic                  ovf_s;

  // Datapath for one conversion step and the range check on its result.
  always_comb begin
    digit_s    = bcd_q[{idx_q, 2'b00} +: 4];
    step_acc_s = (acc_q << 3'd3) + (acc_q << 3'd1) + {{(ACC_W-4){1'b0}}, digit_s};
    step_bad_s = bad_q | (digit_s > 4'd9);
    acc_ext_s  = {{BIN_W{1'b0}}, step_acc_s};
    ovf_s      = (acc_ext_s > {{ACC_W{1'b0}}, {BIN_W{1'b1}}});
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    bad_d   = bad_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    bin_d   = bin_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          bcd_d   = bcd_in;
          acc_d   = {ACC_W{1'b0}};
          idx_d   = IDX_LAST;
          bad_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = S_CONV;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CONV: begin
        acc_d = step_acc_s;
        bad_d = step_bad_s;
        idx_d = idx_q - {{(IDX_W-1){1'b0}}, 1'b1};
        if (idx_q == {IDX_W{1'b0}}) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          // A bad digit wins over overflow; overflow reports the truncated value.
          if (step_bad_s) begin
            err_d = 1'b1;
            bin_d = {BIN_W{1'b0}};
          end else begin
            err_d = ovf_s;
            bin_d = acc_ext_s[BIN_W-1:0];
          end
        end else begin
          state_d = S_CONV;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      bcd_q   <= {(4*DIGITS){1'b0}};
      acc_q   <= {ACC_W{1'b0}};
      idx_q   <= {IDX_W{1'b0}};
      bad_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      bin_q   <= {BIN_W{1'b0}};
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      bad_q   <= bad_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      bin_q   <= bin_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign bin_out = bin_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Scoreboard bench for bcd_to_bin_seq: a cycle model predicts busy/done and pushes
// expected results on accept; a negedge monitor pops and compares them.
module tb_bcd_to_bin_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [11:0] bcd_in;
  logic        busy;
  logic        done;
  logic [9:0]  bin_out;
  logic        err;

  logic        start4;
  logic [15:0] bcd4;
  logic        busy4;
  logic        done4;
  logic [9:0]  bin4;
  logic        err4;

  typedef struct {
    int bin;
    bit err;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   mcnt     = 0;
  bit   exp_busy = 1'b0;
  bit   exp_done = 1'b0;
  int   exp_bin  = 0;
  bit   exp_err  = 1'b0;
  bit   mon_en   = 1'b0;

  bcd_to_bin_seq #(.DIGITS(3), .BIN_W(10)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bcd_in  (bcd_in),
    .busy    (busy),
    .done    (done),
    .bin_out (bin_out),
    .err     (err)
  );

  bcd_to_bin_seq #(.DIGITS(4), .BIN_W(10)) dut4 (
    .clk     (clk),
    .rst     (rst),
    .start   (start4),
    .bcd_in  (bcd4),
    .busy    (busy4),
    .done    (done4),
    .bin_out (bin4),
    .err     (err4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, expv, cyc);
    end
  endtask

  function automatic void ref_conv(input logic [15:0] b, input int nd, input int bw,
                                   output int bin, output bit e);
    int v;
    bit bad;
    int d;
    v   = 0;
    bad = 1'b0;
    for (int i = nd - 1; i >= 0; i--) begin
      d = int'((b >> (4 * i)) & 16'hF);
      if (d > 9) bad = 1'b1;
      v = v * 10 + d;
    end
    if (bad) begin
      e = 1'b1; bin = 0;
    end else if (v > (1 << bw) - 1) begin
      e = 1'b1; bin = v % (1 << bw);
    end else begin
      e = 1'b0; bin = v;
    end
  endfunction

  // Reference timing model: accept only when idle, done DIGITS edges later.
  initial begin
    int eb;
    bit ee;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        mcnt = 0;
        sb_q.delete();
        exp_bin = 0;
        exp_err = 1'b0;
      end else if (mcnt == 0) begin
        if (start) begin
          ref_conv({4'h0, bcd_in}, 3, 10, eb, ee);
          sb_q.push_back('{eb, ee});
          mcnt = 4;
        end
      end else begin
        mcnt--;
      end
      exp_busy = (mcnt >= 2);
      exp_done = (mcnt == 1);
    end
  end

  // Output monitor away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check_eq("busy", 32'(busy), 32'(exp_busy));
        check_eq("done", 32'(done), 32'(exp_done));
        if (exp_done) begin
          if (sb_q.size() == 0) begin
            check_eq("sb_size", 32'(sb_q.size()), 32'd1);
          end else begin
            e = sb_q.pop_front();
            exp_bin = e.bin;
            exp_err = e.err;
          end
        end
        check_eq("bin_out", 32'(bin_out), 32'(exp_bin));
        check_eq("err", 32'(err), 32'(exp_err));
      end
    end
  end

  task automatic convert(input logic [11:0] b);
    @(negedge clk);
    bcd_in = b;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    bcd_in = 12'($urandom);
    repeat (3) @(negedge clk);
  endtask

  task automatic conv4(input logic [15:0] b);
    int k;
    int eb;
    bit ee;
    ref_conv(b, 4, 10, eb, ee);
    @(negedge clk);
    bcd4   = b;
    start4 = 1'b1;
    k = 0;
    for (int j = 1; j <= 10; j++) begin
      @(negedge clk);
      start4 = 1'b0;
      bcd4   = 16'($urandom);
      if (done4 && k == 0) k = j;
    end
    check_eq("dut4_latency", 32'(k), 32'd5);
    check_eq("dut4_bin", 32'(bin4), 32'(eb));
    check_eq("dut4_err", 32'(err4), 32'(ee));
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    bcd_in = 12'h000;
    start4 = 1'b0;
    bcd4   = 16'h0000;
    @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    convert(12'h999);
    convert(12'h000);
    convert(12'h507);
    convert(12'h1A3);
    convert(12'h042);

    // start held for ten cycles: accepts only at the first edge and five later
    @(negedge clk);
    bcd_in = 12'h123;
    start  = 1'b1;
    repeat (10) @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);

    // reset lands on the third edge of a conversion
    bcd_in = 12'h888;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    convert(12'h321);

    for (int i = 0; i < 1000; i++) begin
      convert({4'(i / 100), 4'((i / 10) % 10), 4'(i % 10)});
    end
    for (int i = 0; i < 20; i++) begin
      convert(12'($urandom));
    end
    repeat (6) @(negedge clk);
    check_eq("sb_drain", 32'(sb_q.size()), 32'd0);

    conv4(16'h1024);
    check_eq("dut4_1024_bin", 32'(bin4), 32'd0);
    check_eq("dut4_1024_err", 32'(err4), 32'd1);
    conv4(16'h1023);
    check_eq("dut4_1023_bin", 32'(bin4), 32'd1023);
    check_eq("dut4_1023_err", 32'(err4), 32'd0);
    conv4(16'h9999);
    conv4(16'h20F0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
